sparse_layer_sequencer: RTL and testbench

//  Sequences one input-layer pass of the binary neural network around the input queue register.

---
 rtl/sparse_layer_sequencer_pkg.sv | 24 ++
 rtl/sparse_layer_sequencer_wait_timer.sv | 34 +++
 rtl/sparse_layer_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sparse_layer_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_layer_sequencer_pkg.sv
// Shared constants and types for the input-layer sequencer and its queue.
//   INPUT_LAYER_NODES : pixels per image
//   QUEUE_MAX_SIZE    : input queue storage slots; the queue and the sequencer both use this value
//   CNT_W             : width of every sequencer counter (10 bits, so node counts up to 1023)
//   seq_state_t       : sequencer FSM states
package sparse_layer_sequencer_pkg;

  localparam int INPUT_LAYER_NODES = 784;
  localparam int QUEUE_MAX_SIZE    = 11;
  localparam int CNT_W             = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DQ_HI,
    S_DQ_LO,
    S_LATCH,
    S_WAIT,
    S_ACC,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/sparse_layer_sequencer_wait_timer.sv
// Countdown timer that covers the weight-RAM read latency.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   load         : load load_value into the counter (takes priority over counting)
//   load_value   : number of cycles to wait after the load cycle
//   expired      : high for exactly one cycle, the last cycle of the wait
module sequencer_wait_timer
  import sparse_layer_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  // count==1 is the final wait cycle; the counter then parks at 0, so this is a single pulse.
  assign expired = (count == ONE);

endmodule

// File: rtl/sparse_layer_sequencer.sv
// Sequences one input-layer pass of the binary neural network around the input queue:
// clear the queue, stream INPUT_NODES pixels into it, then pop each queued active-pixel
// index and issue one weight-row read plus one accumulate strobe per index.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : begin a pass (only honoured in IDLE)
//   pixelIn       : pixel currently presented to the queue
//   queueIndex    : queue head index after a pop
//   queueEmpty    : queue empty flag
//   pixelReq      : source presents the next pixel this cycle
//   queueReset    : queue reset
//   queueDequeue  : queue dequeue (queue pops on its falling edge)
//   weightAddr    : weight-row address, the last popped index
//   weightRd      : one-cycle weight read strobe
//   accClear      : one-cycle hidden accumulator clear
//   accEn         : one-cycle accumulate strobe
//   busy          : high outside IDLE
//   done          : one-cycle end-of-pass pulse
//   activeCount   : number of 1-pixels seen in the last load phase
//   overflowErr   : sticky, more active pixels than queue slots
//   mismatchErr   : sticky, queue empty flag disagreed with the expected count
module sparse_layer_sequencer
  import sparse_layer_sequencer_pkg::*;
#(
  parameter int INPUT_NODES = INPUT_LAYER_NODES,
  parameter int QUEUE_DEPTH = QUEUE_MAX_SIZE,
  parameter int MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pixelIn,
  input  logic [CNT_W-1:0] queueIndex,
  input  logic             queueEmpty,
  output logic             pixelReq,
  output logic             queueReset,
  output logic             queueDequeue,
  output logic [CNT_W-1:0] weightAddr,
  output logic             weightRd,
  output logic             accClear,
  output logic             accEn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] activeCount,
  output logic             overflowErr,
  output logic             mismatchErr
);

  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(INPUT_NODES - 1);
  localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] LATENCY    = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] total_count;
  logic             last_pixel;
  logic             wait_expired;

  // Count including the pixel presented this cycle, so the final LOAD cycle sees the full total.
  assign total_count = activeCount + {{(CNT_W-1){1'b0}}, pixelIn};
  assign last_pixel  = (load_cnt == LAST_PIXEL);

  sequencer_wait_timer u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state == S_LATCH),
    .load_value (LATENCY),
    .expired    (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pixelReq     = 1'b0;
    queueReset   = 1'b0;
    queueDequeue = 1'b0;
    weightRd     = 1'b0;
    accClear     = 1'b0;
    accEn        = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        busy       = 1'b0;
        queueReset = 1'b1;
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        queueReset = 1'b1;
        accClear   = 1'b1;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        pixelReq = 1'b1;
        // remaining = min(total, depth) is zero exactly when no pixel was active.
        if (last_pixel) state_next = (total_count == '0) ? S_DONE : S_DQ_HI;
      end
      S_DQ_HI: begin
        // An empty queue here means fewer entries than counted: abandon the pops.
        if (queueEmpty) begin
          state_next = S_DONE;
        end else begin
          queueDequeue = 1'b1;
          state_next   = S_DQ_LO;
        end
      end
      S_DQ_LO: state_next = S_LATCH;
      S_LATCH: begin
        weightRd   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_expired) state_next = S_ACC;
      end
      S_ACC: begin
        accEn      = 1'b1;
        state_next = (remaining == ONE) ? S_DONE : S_DQ_HI;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt    <= '0;
      remaining   <= '0;
      activeCount <= '0;
      weightAddr  <= '0;
      overflowErr <= 1'b0;
      mismatchErr <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          load_cnt    <= '0;
          activeCount <= '0;
          overflowErr <= 1'b0;
          mismatchErr <= 1'b0;
        end
        S_LOAD: begin
          load_cnt    <= load_cnt + ONE;
          activeCount <= total_count;
          if (last_pixel) begin
            remaining   <= (total_count > DEPTH) ? DEPTH : total_count;
            overflowErr <= (total_count > DEPTH);
          end
        end
        S_DQ_HI: begin
          if (queueEmpty) mismatchErr <= 1'b1;
        end
        S_LATCH: weightAddr <= queueIndex;
        S_ACC: begin
          remaining <= remaining - ONE;
          // Last expected entry consumed: the queue should now be drained.
          if (remaining == ONE && !queueEmpty) mismatchErr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_layer_sequencer.sv
module tb_sparse_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pixelIn;
  logic [9:0] queueIndex;
  logic       queueEmpty;
  logic       pixelReq, queueReset, queueDequeue, weightRd, accClear, accEn, busy, done;
  logic [9:0] weightAddr, activeCount;
  logic       overflowErr, mismatchErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sparse_layer_sequencer #(
    .INPUT_NODES (16),
    .QUEUE_DEPTH (4),
    .MEM_LATENCY (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pixelIn      (pixelIn),
    .queueIndex   (queueIndex),
    .queueEmpty   (queueEmpty),
    .pixelReq     (pixelReq),
    .queueReset   (queueReset),
    .queueDequeue (queueDequeue),
    .weightAddr   (weightAddr),
    .weightRd     (weightRd),
    .accClear     (accClear),
    .accEn        (accEn),
    .busy         (busy),
    .done         (done),
    .activeCount  (activeCount),
    .overflowErr  (overflowErr),
    .mismatchErr  (mismatchErr)
  );

  // Pixel source and behavioural 4-slot queue (pops on the falling edge of dequeue).
  logic [15:0] img;
  bit          force_empty;
  int          pix_cnt, q_cnt, q_wr, q_rd, pops;
  logic [9:0]  q_mem [0:15];
  logic        prev_deq;

  always_comb pixelIn = pixelReq ? img[pix_cnt[3:0]] : 1'b0;
  always_comb queueEmpty = (q_cnt == 0) || (force_empty && pops >= 1);

  always @(posedge clk) begin
    prev_deq <= queueDequeue;
    if (queueReset) begin
      pix_cnt    <= 0;
      q_cnt      <= 0;
      q_wr       <= 0;
      q_rd       <= 0;
      pops       <= 0;
      queueIndex <= 10'd0;
    end else begin
      if (pixelReq) begin
        pix_cnt <= pix_cnt + 1;
        if (pixelIn && q_cnt < 4) begin
          q_mem[q_wr[3:0]] <= 10'(pix_cnt);
          q_wr             <= q_wr + 1;
          q_cnt            <= q_cnt + 1;
        end
      end else if (prev_deq && !queueDequeue && q_cnt > 0) begin
        queueIndex <= q_mem[q_rd[3:0]];
        q_rd       <= q_rd + 1;
        q_cnt      <= q_cnt - 1;
        pops       <= pops + 1;
      end
    end
  end

  // Strobe monitor: counts events and records the address seen at each accumulate.
  int         acc_total = 0, rd_total = 0, dq_total = 0, inv_bad = 0;
  logic [9:0] acc_log [0:63];

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (accEn === 1'b1) begin
        acc_log[acc_total[5:0]] = weightAddr;
        acc_total++;
      end
      if (weightRd === 1'b1) rd_total++;
      if (queueDequeue === 1'b1 && prev_deq !== 1'b1) dq_total++;
      if (weightRd === 1'b1 && accEn === 1'b1) inv_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts a pass and counts edges from the accepting edge to the first cycle with done high.
  task automatic run_pass(input logic [15:0] image, input bit fe, output int done_cyc);
    img         = image;
    force_empty = fe;
    start       = 1'b1;
    done_cyc    = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0]     img;
    bit              fe;
    int              exp_done;
    int              exp_acc;
    logic [9:0]      exp_active;
    logic            exp_ovf;
    logic            exp_mis;
    logic [3:0][9:0] exp_addr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dc, acc0, rd0, dq0, c;
    bit found;

    vecs[0] = '{16'h0000, 1'b0, 18, 0, 10'd0, 1'b0, 1'b0, {10'd0, 10'd0, 10'd0, 10'd0}};
    vecs[1] = '{16'h0208, 1'b0, 30, 2, 10'd2, 1'b0, 1'b0, {10'd0, 10'd0, 10'd9, 10'd3}};
    vecs[2] = '{16'h800F, 1'b0, 42, 4, 10'd5, 1'b1, 1'b0, {10'd3, 10'd2, 10'd1, 10'd0}};
    vecs[3] = '{16'h0208, 1'b1, 25, 1, 10'd2, 1'b0, 1'b1, {10'd0, 10'd0, 10'd0, 10'd3}};
    vecs[4] = '{16'h8000, 1'b0, 24, 1, 10'd1, 1'b0, 1'b0, {10'd0, 10'd0, 10'd0, 10'd15}};
    vecs[5] = '{16'h1111, 1'b0, 42, 4, 10'd4, 1'b0, 1'b0, {10'd12, 10'd8, 10'd4, 10'd0}};

    img = 16'h0; force_empty = 1'b0; start = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_queueReset", queueReset, 1);
    chk("reset_strobes", {pixelReq, queueDequeue, weightRd, accClear, accEn, done}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_regs", {weightAddr, activeCount, overflowErr, mismatchErr}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      acc0 = acc_total; rd0 = rd_total; dq0 = dq_total;
      run_pass(vecs[v].img, vecs[v].fe, dc);
      chk($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done);
      chk($sformatf("v%0d_acc_count", v), acc_total - acc0, vecs[v].exp_acc);
      chk($sformatf("v%0d_rd_count", v), rd_total - rd0, vecs[v].exp_acc);
      chk($sformatf("v%0d_dq_count", v), dq_total - dq0, vecs[v].exp_acc);
      for (int i = 0; i < vecs[v].exp_acc && i < acc_total - acc0; i++)
        chk($sformatf("v%0d_addr%0d", v, i), acc_log[6'(acc0 + i)], vecs[v].exp_addr[i]);
      chk($sformatf("v%0d_activeCount", v), activeCount, vecs[v].exp_active);
      chk($sformatf("v%0d_overflowErr", v), overflowErr, vecs[v].exp_ovf);
      chk($sformatf("v%0d_mismatchErr", v), mismatchErr, vecs[v].exp_mis);
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_after_done", v), {busy, done, queueReset}, 3'b001);
      force_empty = 1'b0;
    end

    // Reset during the first WAIT, then a clean repeat of the two-pixel pass.
    img = 16'h0208; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (weightRd === 1'b1) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rst_reach_latch", found, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_strobes_low", {weightRd, accEn}, 0);
    chk("rst_queueReset", queueReset, 1);
    chk("rst_busy", busy, 0);
    acc0 = acc_total;
    run_pass(16'h0208, 1'b0, dc);
    chk("rst_rerun_done_cycle", dc, 30);
    chk("rst_rerun_acc_count", acc_total - acc0, 2);
    chk("rst_rerun_addr0", acc_log[6'(acc0)], 3);
    chk("rst_rerun_addr1", acc_log[6'(acc0 + 1)], 9);
    chk("rst_rerun_errs", {overflowErr, mismatchErr}, 0);
    @(posedge clk); #1;

    // start pulsed during LOAD must not disturb the pass or trigger a second one.
    img = 16'h0208; start = 1'b1;
    dc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start = (k == 5) ? 1'b1 : 1'b0;
      if (done === 1'b1) begin dc = k; break; end
    end
    chk("load_start_done_cycle", dc, 30);
    c = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) c++;
    end
    chk("load_start_no_restart", c, 0);

    // start held high through DONE: one IDLE cycle, then a new CLEAR that drops the flags.
    run_pass(16'h800F, 1'b0, dc);
    start = 1'b1;
    chk("hold_first_done_cycle", dc, 42);
    chk("hold_first_overflow", overflowErr, 1);
    img = 16'h0208;
    @(posedge clk); #1;
    chk("hold_idle_gap", {busy, queueReset, overflowErr}, 3'b011);
    @(posedge clk); #1;
    chk("hold_clear_state", {busy, queueReset, accClear}, 3'b111);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_flags_cleared", {overflowErr, mismatchErr, activeCount}, 0);
    chk("hold_load_pixelReq", pixelReq, 1);
    acc0 = acc_total;
    dc = -1;
    for (int k = 3; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin dc = k; break; end
    end
    chk("hold_second_done_cycle", dc, 30);
    chk("hold_second_acc_count", acc_total - acc0, 2);
    chk("hold_second_addr1", acc_log[6'(acc0 + 1)], 9);
    chk("hold_second_overflow", overflowErr, 0);
    @(posedge clk); #1;

    chk("rd_acc_exclusive", inv_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
